// File: rtl/fc_layer_par_mac.sv
// Fully-connected layer engine with P parallel MAC lanes and W/B coefficient RAM.
// Define FC_RELU_EN to clamp negative saturated results to zero (ReLU layer).
module fc_layer_par_mac #(
    parameter int T = 16,
    parameter int N = 4,
    parameter int M = 4,
    parameter int P = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [T-1:0]                data_in,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [T-1:0]                data_out,
    input  logic                        cfg_wr,
    input  logic [$clog2(M*N+M)-1:0]    cfg_addr,
    input  logic [T-1:0]                cfg_data,
    output logic                        cfg_ready
);
    localparam int ACCW = 2*T + $clog2(N) + 1;
    localparam int WA   = $clog2(M*N);
    localparam int NW   = $clog2(N);
    localparam int CW   = $clog2(N+2);
    localparam int G    = M / P;
    localparam int GW   = (G > 1) ? $clog2(G) : 1;
    localparam int LW   = (P > 1) ? $clog2(P) : 1;
    localparam int BW   = (M > 1) ? $clog2(M) : 1;

    localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SMIN = {{(ACCW-T+1){1'b1}}, {(T-1){1'b0}}};

    generate
        if (M % P != 0) begin : g_bad_p
            $error("fc_layer_par_mac: M must be a multiple of P");
        end
    endgenerate

    typedef enum logic [1:0] {LOAD, MAC, FINAL, OUT} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [GW-1:0]          g;
    logic [LW-1:0]          lane;

    logic signed [T-1:0]    w_mem [M*N];
    logic signed [T-1:0]    b_mem [M];
    logic signed [T-1:0]    x_mem [N];

    logic signed [T-1:0]    w_q [P];
    logic signed [T-1:0]    x_q;
    logic signed [2*T-1:0]  prod [P];
    logic signed [ACCW-1:0] acc [P];
    logic signed [ACCW-1:0] sum [P];
    logic signed [T-1:0]    res_nx [P];
    logic signed [T-1:0]    res [P];
    logic                   rd_vld;
    logic                   mul_vld;
    logic                   s_fire;
    logic                   issue;
    logic                   mac_entry;

    assign s_fire = s_valid && s_ready;
    assign issue  = (state == MAC) && (int'(cnt) < N);
    assign mac_entry = (state == LOAD && s_fire && int'(cnt) == N-1)
                    || (state == OUT && m_ready && lane == LW'(P-1)
                        && int'(g) != G-1);

    // Coefficient and sample storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (cfg_wr && cfg_ready) begin
            if (int'(cfg_addr) < M*N)
                w_mem[WA'(cfg_addr)] <= cfg_data;
            else if (int'(cfg_addr) < M*N+M)
                b_mem[BW'(int'(cfg_addr) - M*N)] <= cfg_data;
        end
        if (state == LOAD && s_fire)
            x_mem[cnt[NW-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld  <= 1'b0;
            mul_vld <= 1'b0;
            x_q     <= '0;
            for (int k = 0; k < P; k++) begin
                w_q[k]  <= '0;
                prod[k] <= '0;
                acc[k]  <= '0;
            end
        end else begin
            rd_vld  <= issue;
            mul_vld <= rd_vld;
            if (issue) begin
                x_q <= x_mem[cnt[NW-1:0]];
                for (int k = 0; k < P; k++)
                    w_q[k] <= w_mem[WA'(int'(g)*P*N + k*N + int'(cnt))];
            end
            for (int k = 0; k < P; k++) begin
                if (rd_vld)
                    prod[k] <= w_q[k] * x_q;
                if (mac_entry)
                    acc[k] <= '0;
                else if (mul_vld)
                    acc[k] <= acc[k] + ACCW'(prod[k]);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < P; k++) begin
            sum[k] = acc[k] + ACCW'(b_mem[BW'(int'(g)*P + k)]);
            if (sum[k] > SMAX)
                res_nx[k] = SMAX[T-1:0];
            else if (sum[k] < SMIN)
                res_nx[k] = SMIN[T-1:0];
            else
                res_nx[k] = sum[k][T-1:0];
`ifdef FC_RELU_EN
            if (res_nx[k][T-1])
                res_nx[k] = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= LOAD;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            data_out  <= '0;
            cfg_ready <= 1'b1;
            cnt       <= '0;
            g         <= '0;
            lane      <= '0;
            for (int k = 0; k < P; k++)
                res[k] <= '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (s_fire) begin
                        cfg_ready <= 1'b0;
                        if (int'(cnt) == N-1) begin
                            cnt     <= '0;
                            s_ready <= 1'b0;
                            state   <= MAC;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                // Issue N indices, then two cycles for read/multiply drain.
                MAC: begin
                    if (int'(cnt) == N+1) begin
                        cnt   <= '0;
                        state <= FINAL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FINAL: begin
                    for (int k = 0; k < P; k++)
                        res[k] <= res_nx[k];
                    data_out <= res_nx[0];
                    m_valid  <= 1'b1;
                    lane     <= '0;
                    state    <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        if (lane == LW'(P-1)) begin
                            m_valid <= 1'b0;
                            lane    <= '0;
                            if (int'(g) == G-1) begin
                                g         <= '0;
                                s_ready   <= 1'b1;
                                cfg_ready <= 1'b1;
                                state     <= LOAD;
                            end else begin
                                g     <= g + GW'(1);
                                state <= MAC;
                            end
                        end else begin
                            lane     <= lane + LW'(1);
                            data_out <= res[lane + LW'(1)];
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fc_layer_par_mac.sv
// Directed and throttled checks for fc_layer_par_mac at N=4, M=4, P=2, T=16.
// Expectations follow FC_RELU_EN when it is defined for the build.
module tb_fc_layer_par_mac;
    localparam int T  = 16;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int P  = 2;
    localparam int AW = $clog2(M*N+M);

    typedef logic [N-1:0][T-1:0]   xv_t;
    typedef logic [M-1:0][T-1:0]   yv_t;
    typedef logic [M*N-1:0][T-1:0] wv_t;
    typedef struct packed {
        wv_t w;
        yv_t b;
        xv_t x;
        yv_t y;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [T-1:0]  data_in = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [T-1:0]  data_out;
    logic          cfg_wr = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [T-1:0]  cfg_data = '0;
    logic          cfg_ready;

    fc_layer_par_mac #(.T(T), .N(N), .M(M), .P(P)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_valid(s_valid), .s_ready(s_ready), .data_in(data_in),
        .m_valid(m_valid), .m_ready(m_ready), .data_out(data_out),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int   n_chk = 0;
    int   n_fail = 0;
    int   hs_cyc = 0;
    int   out_cyc = 0;
    wv_t  cur_w;
    yv_t  cur_b;
    vec_t tv [5];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_addr = AW'(addr);
        cfg_data = T'(data);
        cfg_wr   = 1'b1;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    task automatic load(input wv_t w, input yv_t b);
        for (int i = 0; i < M*N; i++) cfg_write(i, int'(w[i]));
        for (int m = 0; m < M; m++) cfg_write(M*N + m, int'(b[m]));
        cur_w = w;
        cur_b = b;
    endtask

    task automatic send(input xv_t x, input bit throttle);
        int n;
        for (int j = 0; j < N; j++) begin
            if (throttle) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            s_valid = 1'b1;
            data_in = x[j];
            n = 0;
            while (!s_ready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (n >= 300) begin
                chk("s_ready timeout", 0, 1);
                s_valid = 1'b0;
                return;
            end
            hs_cyc = cyc;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic collect(input yv_t y, input int first, input int cnt,
                           input bit throttle, input string name);
        int n;
        for (int m = first; m < first + cnt; m++) begin
            n = 0;
            m_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!(m_valid && m_ready) && n < 400) begin
                @(negedge clk);
                n++;
                m_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (n >= 400) begin
                chk($sformatf("%s m_valid timeout", name), 0, 1);
                m_ready = 1'b0;
                return;
            end
            if (m == 0) out_cyc = cyc;
            chk($sformatf("%s y%0d", name, m),
                int'($signed(data_out)), int'($signed(y[m])));
            @(negedge clk);
        end
        m_ready = 1'b0;
    endtask

    function automatic int ref_y(input int m, input xv_t x);
        longint s;
        s = longint'($signed(cur_b[m]));
        for (int j = 0; j < N; j++)
            s += longint'($signed(cur_w[m*N+j])) * longint'($signed(x[j]));
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    initial begin
        yv_t  ye;
        xv_t  rx;
        wv_t  rw;
        yv_t  rb;
        int   n;

        for (int k = 0; k < M*N; k++) begin
            tv[0].w[k] = T'(1);
            tv[1].w[k] = (k % N == 0) ? T'(k / N + 1) : T'(0);
            tv[2].w[k] = T'(32767);
            tv[3].w[k] = T'(-32768);
            tv[4].w[k] = T'((k % N) - (k / N));
        end
        for (int m = 0; m < M; m++) begin
            tv[0].b[m] = T'(0);
            tv[2].b[m] = T'(32767);
            tv[3].b[m] = T'(0);
            tv[0].x[m] = T'(m + 1);
            tv[2].x[m] = T'(32767);
            tv[3].x[m] = T'(32767);
            tv[4].x[m] = T'(10 * (m + 1));
            tv[0].y[m] = T'(10);
            tv[2].y[m] = T'(32767);
        end
        tv[1].b = {T'(-1), T'(5), T'(0), T'(-3)};
        tv[1].x = {T'(9), T'(9), T'(9), T'(2)};
        tv[4].b = {T'(7), T'(0), T'(-100), T'(100)};
`ifdef FC_RELU_EN
        tv[1].y = {T'(7), T'(11), T'(4), T'(0)};
        tv[3].y = {T'(0), T'(0), T'(0), T'(0)};
        tv[4].y = {T'(0), T'(0), T'(0), T'(300)};
`else
        tv[1].y = {T'(7), T'(11), T'(4), T'(-1)};
        tv[3].y = {T'(-32768), T'(-32768), T'(-32768), T'(-32768)};
        tv[4].y = {T'(-93), T'(0), T'(0), T'(300)};
`endif

        repeat (3) @(negedge clk);
        chk("reset s_ready", int'(s_ready), 1);
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset data_out", int'(data_out), 0);
        chk("reset cfg_ready", int'(cfg_ready), 1);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            load(tv[i].w, tv[i].b);
            send(tv[i].x, 1'b0);
            chk($sformatf("vec%0d cfg_ready busy", i), int'(cfg_ready), 0);
            chk($sformatf("vec%0d s_ready busy", i), int'(s_ready), 0);
            collect(tv[i].y, 0, M, 1'b0, $sformatf("vec%0d", i));
            if (i == 0) chk("latency", out_cyc - hs_cyc, 8);
            chk($sformatf("vec%0d s_ready back", i), int'(s_ready), 1);
            chk($sformatf("vec%0d m_valid done", i), int'(m_valid), 0);
        end

        cfg_write(20, 5000);
        cfg_write(31, 7);
        send(tv[4].x, 1'b0);
        collect(tv[4].y, 0, M, 1'b0, "oor");

        send(tv[4].x, 1'b0);
        n = 0;
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall m_valid arrives", int'(m_valid), 1);
        for (int c = 0; c < 5; c++) begin
            chk("stall m_valid", int'(m_valid), 1);
            chk("stall data_out", int'($signed(data_out)),
                int'($signed(tv[4].y[0])));
            chk("stall s_ready", int'(s_ready), 0);
            if (c == 1) begin
                chk("stall cfg_ready", int'(cfg_ready), 0);
                cfg_write(0, 999);
            end else begin
                @(negedge clk);
            end
        end
        for (int m = 0; m < M; m++) begin
            chk("stall s_ready hold", int'(s_ready), 0);
            collect(tv[4].y, m, 1, 1'b0, "stall");
        end
        chk("stall s_ready release", int'(s_ready), 1);
        send(tv[4].x, 1'b0);
        collect(tv[4].y, 0, M, 1'b0, "cfg ignored");

        send(tv[4].x, 1'b0);
        collect(tv[4].y, 0, 2, 1'b0, "pre-reset");
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset m_valid", int'(m_valid), 0);
        chk("midreset s_ready", int'(s_ready), 1);
        chk("midreset cfg_ready", int'(cfg_ready), 1);
        chk("midreset data_out", int'(data_out), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(tv[4].x, 1'b0);
        collect(tv[4].y, 0, M, 1'b0, "post-reset");

        for (int k = 0; k < M*N; k++)
            rw[k] = T'(int'($urandom_range(0, 600)) - 300);
        for (int m = 0; m < M; m++)
            rb[m] = T'(int'($urandom_range(0, 2000)) - 1000);
        load(rw, rb);
        for (int v = 0; v < 30; v++) begin
            for (int j = 0; j < N; j++)
                rx[j] = T'(int'($urandom_range(0, 400)) - 200);
            for (int m = 0; m < M; m++)
                ye[m] = T'(ref_y(m, rx));
            send(rx, 1'b1);
            collect(ye, 0, M, 1'b1, $sformatf("rnd%0d", v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
